// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Purpose  : Shared state encoding and default address constants for the
//            pc_sequencer, the CPU top level and its bench.
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RUN  = 3'd1;
    localparam logic [2:0] c_STEP = 3'd2;
    localparam logic [2:0] c_DONE = 3'd3;
    localparam logic [2:0] c_ERR  = 3'd4;

    localparam int unsigned c_RESET_PC = 0;
    localparam int unsigned c_END_PC   = 60;
    localparam int unsigned c_PC_STEP  = 4;

endpackage
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_sel
// Purpose  : Combinational next-pc select (jump > branch > sequential) with
//            word-alignment check on the chosen redirect target.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned PC_STEP = c_PC_STEP
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign
);

    always_comb begin
        next_pc  = pc + ADDR_W'(PC_STEP);
        misalign = 1'b0;
        if (jump) begin
            next_pc  = jump_target;
            misalign = (jump_target[1:0] != 2'b00);
        end else if (branch_taken) begin
            next_pc  = branch_target;
            misalign = (branch_target[1:0] != 2'b00);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Run/stop/single-step fetch controller owning the program counter,
//            with redirects, stalls, end-of-program and retire counting.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned PC_STEP  = c_PC_STEP,
    parameter int unsigned RESET_PC = c_RESET_PC,
    parameter int unsigned END_PC   = c_END_PC,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              busy,
    output logic              done,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  instr_cnt
);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_cnt;

    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_sel_pc;
    logic              w_misalign;
    logic              w_retire;
    logic              w_redirect;

    pc_next_sel #(
        .ADDR_W  (ADDR_W),
        .PC_STEP (PC_STEP)
    ) u_next_sel (
        .pc            (r_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .next_pc       (w_sel_pc),
        .misalign      (w_misalign)
    );

    assign w_redirect = jump | branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_pc    <= ADDR_W'(RESET_PC);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_retire    = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (start)     w_state_nxt = c_RUN;
                else if (step) w_state_nxt = c_STEP;
            end
            c_RUN: begin
                if (stop)        w_state_nxt = c_IDLE;
                else if (!stall) w_retire    = 1'b1;
            end
            c_STEP: begin
                if (!stall) w_retire = 1'b1;
            end
            c_DONE, c_ERR: begin
                if (start) begin
                    w_state_nxt = c_RUN;
                    w_pc_nxt    = ADDR_W'(RESET_PC);
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase

        // A single step returns to IDLE unless the retire ends the program.
        if (w_retire) begin
            w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
            if (w_misalign) begin
                w_state_nxt = c_ERR;
            end else if (!w_redirect && r_pc == ADDR_W'(END_PC)) begin
                w_state_nxt = c_DONE;
            end else begin
                w_pc_nxt = w_sel_pc;
                if (r_state == c_STEP) w_state_nxt = c_IDLE;
            end
        end
    end

    assign pc           = r_pc;
    assign pc_valid     = (r_state == c_RUN) || (r_state == c_STEP);
    assign busy         = (r_state == c_RUN) || (r_state == c_STEP);
    assign done         = (r_state == c_DONE) || (r_state == c_ERR);
    assign misalign_err = (r_state == c_ERR);
    assign instr_cnt    = r_cnt;

endmodule
`default_nettype wire
